// File: rtl/l2_vram_ctrl_if.sv
// Request/response bundle between the L1 video caches and the shared L2 controller.
// Optional scanout signals exist only when L2_SCANOUT_EN is defined.
interface l2_vram_ctrl_if #(
    parameter int N_CORES = 2,
    parameter int ADDR_W  = 10,
    parameter int WORD_W  = 32
);
    // A core raises req_en with req_w/req_addr/req_wdata held stable until its
    // one-cycle ready pulse; dropping req_en earlier abandons the request.
    logic [N_CORES-1:0]        req_en;
    logic [N_CORES-1:0]        req_w;
    logic [N_CORES*ADDR_W-1:0] req_addr;
    logic [N_CORES*WORD_W-1:0] req_wdata;
    logic [WORD_W-1:0]         rdata;
    logic [N_CORES-1:0]        ready;
    logic [N_CORES-1:0]        invalidate;
    logic [ADDR_W-1:0]         inv_addr;
    logic [N_CORES-1:0]        invalidated;
`ifdef L2_SCANOUT_EN
    logic                      sc_en;
    logic [ADDR_W-1:0]         sc_addr;
    logic [WORD_W-1:0]         sc_data;
    logic                      sc_ready;
`endif

    modport master (
        output req_en, req_w, req_addr, req_wdata, invalidated,
`ifdef L2_SCANOUT_EN
        output sc_en, sc_addr,
        input  sc_data, sc_ready,
`endif
        input  rdata, ready, invalidate, inv_addr
    );

    modport slave (
        input  req_en, req_w, req_addr, req_wdata, invalidated,
`ifdef L2_SCANOUT_EN
        input  sc_en, sc_addr,
        output sc_data, sc_ready,
`endif
        output rdata, ready, invalidate, inv_addr
    );
endinterface

// File: rtl/l2_vram_ctrl.sv
// Shared L2 framebuffer responder: round-robin over N L1 caches, invalidates peers
// before each line write. Define L2_SCANOUT_EN to add a lowest-priority scanout read port.
module l2_vram_ctrl #(
    parameter int N_CORES = 2,
    parameter int ADDR_W  = 10,
    parameter int WORD_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    l2_vram_ctrl_if.slave  bus,
    output logic [2:0]     o_dbg_state
);
    localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_INV   = 3'd2,
        S_WRITE = 3'd3,
        S_SCAN  = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic [GW-1:0]      r_ptr, r_g, w_grant_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata, r_mem_q;
    logic [N_CORES-1:0] r_ack, w_ack_all, w_ready, w_inv;
    logic               r_rd_vld, w_grant_vld, w_g_en, w_mem_re, w_mem_we;
    logic [WORD_W-1:0]  r_mem [2**ADDR_W];

    // Scan from the core after the last winner; the nearest requester is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = N_CORES; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % N_CORES;
            if (bus.req_en[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = GW'(idx);
            end
        end
    end

    assign w_g_en = bus.req_en[r_g];

    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_inv     = '0;
        w_mem_re  = 1'b0;
        w_mem_we  = 1'b0;
        w_ack_all = r_ack | bus.invalidated;
`ifdef L2_SCANOUT_EN
        bus.sc_ready = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld)
                    w_next = bus.req_w[w_grant_idx] ? S_INV : S_READ;
`ifdef L2_SCANOUT_EN
                else if (bus.sc_en)
                    w_next = S_SCAN;
`endif
            end
            S_READ: begin
                if (!w_g_en) begin
                    w_next = S_IDLE;
                end else if (r_rd_vld) begin
                    w_ready[r_g] = 1'b1;
                    w_next       = S_IDLE;
                end else begin
                    w_mem_re = 1'b1;
                end
            end
            S_INV: begin
                // Requester's own bit is preset in r_ack, so it is never invalidated.
                w_inv = ~r_ack;
                if (!w_g_en)
                    w_next = S_IDLE;
                else if (&w_ack_all)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                w_ready[r_g] = 1'b1;
                w_mem_we     = 1'b1;
                w_next       = S_IDLE;
            end
`ifdef L2_SCANOUT_EN
            S_SCAN: begin
                if (r_rd_vld) begin
                    bus.sc_ready = 1'b1;
                    w_next       = S_IDLE;
                end else begin
                    w_mem_re = 1'b1;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= GW'(N_CORES - 1);
            r_g      <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rd_vld <= w_mem_re;
            if (r_state == S_IDLE && w_grant_vld) begin
                r_g     <= w_grant_idx;
                r_ptr   <= w_grant_idx;
                r_addr  <= bus.req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
                r_wdata <= bus.req_wdata[int'(w_grant_idx)*WORD_W +: WORD_W];
                r_ack   <= N_CORES'(1) << w_grant_idx;
            end
`ifdef L2_SCANOUT_EN
            else if (r_state == S_IDLE && bus.sc_en) begin
                r_addr <= bus.sc_addr;
            end
`endif
            if (r_state == S_INV)
                r_ack <= w_ack_all;
        end
    end

    // Framebuffer line store; a reset coinciding with the write cycle drops the write.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst)
            r_mem[r_addr] <= r_wdata;
        if (w_mem_re)
            r_mem_q <= r_mem[r_addr];
    end

    assign bus.ready      = w_ready;
    assign bus.rdata      = r_mem_q;
    assign bus.invalidate = w_inv;
    assign bus.inv_addr   = r_addr;
`ifdef L2_SCANOUT_EN
    assign bus.sc_data    = r_mem_q;
`endif
    assign o_dbg_state    = r_state;
endmodule
